// File: rtl/control_unit_pkg.sv
// Shared types and constants for the hardwired control unit.
// Opcode map, FSM state encoding, decoded-opcode flags and the strobe bundle.
package control_unit_pkg;

  localparam int unsigned OPW = 5;
  localparam int unsigned IRW = 32;

  localparam logic [OPW-1:0] ALU_ADD = 5'b00011;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_IDLE = 4'd1,
    ST_T0   = 4'd2,
    ST_T1   = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8,
    ST_T7   = 4'd9,
    ST_HALT = 4'd10
  } state_t;

  typedef struct packed {
    logic is_ld;
    logic is_ldi;
    logic is_st;
    logic is_alu;
    logic is_addi;
    logic is_nop;
    logic is_halt;
    logic is_bad;
  } dec_t;

  // Every Datapath strobe driven by the FSM, in one registered bundle.
  typedef struct packed {
    logic           dp_clear;
    logic           pc_out;
    logic           mdr_out;
    logic           zlo_out;
    logic           r_out;
    logic           c_out;
    logic           ba_out;
    logic           mar_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           zlow_in;
    logic           pc_in;
    logic           r_in;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           inc_pc;
    logic           read;
    logic           write;
    logic           halted;
    logic [OPW-1:0] op_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{dp_clear: 1'b1, default: '0};

endpackage

// File: rtl/control_unit_decode.sv
// Opcode classifier: maps ir[31:27] to one-hot instruction-class flags.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output dec_t           dec_c
);

  always_comb begin
    dec_c = '0;
    case (opcode)
      OP_LD:                         dec_c.is_ld   = 1'b1;
      OP_LDI:                        dec_c.is_ldi  = 1'b1;
      OP_ST:                         dec_c.is_st   = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: dec_c.is_alu  = 1'b1;
      OP_ADDI:                       dec_c.is_addi = 1'b1;
      OP_NOP:                        dec_c.is_nop  = 1'b1;
      OP_HALT:                       dec_c.is_halt = 1'b1;
      default:                       dec_c.is_bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit sequencing the Datapath through fetch (T0-T2)
// and execute (T3-T7); strobes are registered from the next-state decode.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic           stop,
  input  logic [IRW-1:0] ir,
  output logic           dp_clear,
  output logic           PC_out,
  output logic           MDR_out,
  output logic           Zlo_out,
  output logic           R_out,
  output logic           C_out,
  output logic           BAout,
  output logic           MARin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zlowin,
  output logic           PCin,
  output logic           Rin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] op_sel,
  output logic           halted,
  output logic           illegal
);

  logic [OPW-1:0] opcode_c;
  logic           unused_ir_c;
  dec_t           dec_c;
  state_t         state_q, state_d, end_st_c;
  ctrl_t          ctrl_q, ctrl_d;
  logic           illegal_q, illegal_d;

  assign opcode_c    = ir[IRW-1 -: OPW];
  assign unused_ir_c = ^ir[IRW-OPW-1:0];

  control_unit_decode u_decode (
    .opcode (opcode_c),
    .dec_c  (dec_c)
  );

  // Strobes asserted while sitting in state s for the decoded instruction.
  function automatic ctrl_t decode_ctrl(input state_t s, input dec_t d,
                                        input logic [OPW-1:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      ST_INIT: c.dp_clear = 1'b1;
      ST_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlow_in = 1'b1;
      end
      ST_T1: begin
        c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      ST_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      ST_T3: begin
        if (d.is_ld || d.is_ldi || d.is_st) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end else if (d.is_alu || d.is_addi) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end
      end
      ST_T4: begin
        if (d.is_ld || d.is_ldi || d.is_st || d.is_addi) begin
          c.c_out = 1'b1; c.op_sel = ALU_ADD; c.zlow_in = 1'b1;
        end else if (d.is_alu) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.op_sel = opc; c.zlow_in = 1'b1;
        end
      end
      ST_T5: begin
        if (d.is_ld || d.is_st) begin
          c.zlo_out = 1'b1; c.mar_in = 1'b1;
        end else if (d.is_ldi || d.is_alu || d.is_addi) begin
          c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end
      end
      ST_T6: begin
        if (d.is_ld) begin
          c.read = 1'b1; c.mdr_in = 1'b1;
        end else if (d.is_st) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
        end
      end
      ST_T7: begin
        if (d.is_ld) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (d.is_st) begin
          c.write = 1'b1;
        end
      end
      ST_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign end_st_c = stop ? ST_HALT : ST_T0;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: state_d = run ? ST_T0 : ST_IDLE;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        if (dec_c.is_bad) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (dec_c.is_halt) begin
          state_d = ST_HALT;
        end else if (dec_c.is_nop) begin
          state_d = end_st_c;
        end else begin
          state_d = ST_T3;
        end
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (dec_c.is_ldi || dec_c.is_alu || dec_c.is_addi) ? end_st_c : ST_T6;
      ST_T6:   state_d = ST_T7;
      ST_T7:   state_d = end_st_c;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
    ctrl_d = decode_ctrl(state_d, dec_c, opcode_c);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_INIT;
      ctrl_q    <= CTRL_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign dp_clear = ctrl_q.dp_clear;
  assign PC_out   = ctrl_q.pc_out;
  assign MDR_out  = ctrl_q.mdr_out;
  assign Zlo_out  = ctrl_q.zlo_out;
  assign R_out    = ctrl_q.r_out;
  assign C_out    = ctrl_q.c_out;
  assign BAout    = ctrl_q.ba_out;
  assign MARin    = ctrl_q.mar_in;
  assign MDRin    = ctrl_q.mdr_in;
  assign IRin     = ctrl_q.ir_in;
  assign Yin      = ctrl_q.y_in;
  assign Zlowin   = ctrl_q.zlow_in;
  assign PCin     = ctrl_q.pc_in;
  assign Rin      = ctrl_q.r_in;
  assign Gra      = ctrl_q.gra;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign IncPC    = ctrl_q.inc_pc;
  assign Read     = ctrl_q.read;
  assign Write    = ctrl_q.write;
  assign op_sel   = ctrl_q.op_sel;
  assign halted   = ctrl_q.halted;
  assign illegal  = illegal_q;

endmodule
